cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Fetch/decode/execute control FSM for the 8-bit microprocessor.
//  Sequences instruction_memory, register_bank and data_mem over their existing ports.
//  Runs from PC 0 while power=1, and halts after executing the instruction at last_add.
//  Contains no memory arrays; it holds only PC, IR and one operand latch.
// PARAMETERS
//  DW    8  datapath / instruction width
//  PC_W  8  program counter / imem address width
//  DM_AW 4  data_mem address width
//  RB_AW 2  register_bank address width
// PORTS
//  clk       in   1      clock; all state changes on the rising edge
//  reset     in   1      asynchronous, active-high reset
//  power     in   1      run enable
//  last_add  in   PC_W   address of the final program instruction
//  imem_add  out  PC_W   instruction_memory address
//  imem_rw   out  1      1=read, 0=write (this block only reads)
//  imem_op   in   DW     instruction read data
//  rb_r_add  out  RB_AW  register_bank read address
//  rb_w_add  out  RB_AW  register_bank write address
//  rb_rw     out  1      1=read, 0=write
//  rb_ip     out  DW     register write data
//  rb_op     in   DW     register read data
//  dm_r_add  out  DM_AW  data_mem read address
//  dm_w_add  out  DM_AW  data_mem write address
//  dm_rw     out  1      1=read, 0=write
//  dm_ip     out  DW     data_mem write data
//  dm_op     in   DW     data_mem read data
//  pc        out  PC_W   current program counter
//  busy      out  1      high in any state except IDLE and HALT
//  halted    out  1      high in HALT
// BEHAVIOUR
//  Attached memories have a 1-cycle registered read: address driven in state S gives data in S+1.
//  ISA: ir[7:6] opcode, ir[5:4] rd, ir[3:0] dm address, ir[1:0] rs.
//    00 LOAD  rd <= dm[addr]
//    01 STORE dm[addr] <= rd
//    10 ADD   rd <= rd + rs (8-bit wrap, carry dropped)
//    11 JMP   pc <= {4'h0, addr}
//  Outputs are decoded from state/ir (Moore).
//  In every state not listed below: all rw=1, addresses=0, ip=0.
//  State sequence:
//    IDLE   : power=1 -> FETCH with pc=0.
//    FETCH  : imem_add=pc, imem_rw=1 -> DECODE.
//    DECODE : ir<=imem_op; last<=(pc==last_add); pc<=pc+1 (0xFF wraps to 0x00).
//             Next by imem_op[7:6]: LOAD->MEM, STORE/ADD->RD_A, JMP->END (pc<=jump target).
//    MEM    : dm_r_add=addr, dm_rw=1 -> WB.
//    RD_A   : rb_r_add=rd -> ST (STORE) or RD_B (ADD).
//    RD_B   : a<=rb_op; rb_r_add=rs -> WB.
//    ST     : dm_w_add=addr, dm_ip=rb_op, dm_rw=0 -> END.
//    WB     : rb_w_add=rd, rb_rw=0, rb_ip = dm_op (LOAD) or a+rb_op (ADD) -> END.
//    END    : decision in the same cycle as the instruction's last state (ST/WB/DECODE-JMP):
//             last=1 -> HALT; last=0 -> FETCH.
//    HALT   : holds until power=0 -> IDLE.
//  Latency in cycles: LOAD 4, STORE 4, ADD 5, JMP 2.
//  power=0 in any state -> IDLE next edge. Write strobes are gated by power in the same cycle,
//    so no write occurs when power=0.
//  Re-asserting power from IDLE always restarts at pc=0.
//  Reset (any time, mid-instruction included): state=IDLE; pc, ir, a, last = 0;
//    all rw=1, all addresses/ip=0, busy=0, halted=0.
// STRUCTURE
//  cpu_pkg: opcode localparams (OP_LOAD..OP_JMP), state encoding, ir field slice macros.
//  Single module; no sub-module is warranted.
// TESTING
//  1. imem[0]=8'h01, dm[1]=8'h3C, last_add=0, power=1
//     -> WB in cycle 4 writes r0=8'h3C; halted=1 in the next cycle.
//  2. r1=8'hF0, r2=8'h20, imem[0]=8'b10_01_0010
//     -> r1=8'h10 (wrap); 5-cycle latency.
//  3. r0=8'hA5, imem[0]=8'b01_00_0101 -> dm[5]=8'hA5; dm_rw=0 only in ST.
//  4. imem[1]=8'hC0, last_add=3 -> pc loops 0,1,0,...; power dropped during ST
//     -> no dm write, IDLE next edge.
//  5. Async reset asserted mid-RD_B -> outputs return to reset values immediately, before the clock edge.
//  6. HALT, then power 0->1 -> FETCH with imem_add=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: opcodes, FSM state encoding
// and instruction-field helpers.
package cpu_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_JMP   = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEM    = 4'd3,
        ST_RD_A   = 4'd4,
        ST_RD_B   = 4'd5,
        ST_ST     = 4'd6,
        ST_WB     = 4'd7,
        ST_HALT   = 4'd8
    } state_e;

    // Instruction fields: [7:6] opcode, [5:4] rd, [3:0] dm address / jump target, [1:0] rs
    function automatic logic [1:0] ir_op(input logic [7:0] ir);
        return ir[7:6];
    endfunction

    function automatic logic [1:0] ir_rd(input logic [7:0] ir);
        return ir[5:4];
    endfunction

    function automatic logic [3:0] ir_addr(input logic [7:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic [1:0] ir_rs(input logic [7:0] ir);
        return ir[1:0];
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit CPU. Drives instruction memory,
// register bank and data memory (all 1-cycle registered reads); holds PC, IR and one operand.
//
// state  | meaning
// IDLE   | stopped; power=1 starts a run from pc=0
// FETCH  | imem_add=pc
// DECODE | latch IR, advance pc (or jump), record whether this is the last instruction
// MEM    | LOAD: data memory read
// RD_A   | STORE/ADD: read rd
// RD_B   | ADD: latch rd value, read rs
// ST     | STORE: data memory write of rd
// WB     | LOAD/ADD: register write-back
// HALT   | program finished; waits for power=0
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DW    = 8,
    parameter int PC_W  = 8,
    parameter int DM_AW = 4,
    parameter int RB_AW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             power,
    input  logic [PC_W-1:0]  last_add,
    output logic [PC_W-1:0]  imem_add,
    output logic             imem_rw,
    input  logic [DW-1:0]    imem_op,
    output logic [RB_AW-1:0] rb_r_add,
    output logic [RB_AW-1:0] rb_w_add,
    output logic             rb_rw,
    output logic [DW-1:0]    rb_ip,
    input  logic [DW-1:0]    rb_op,
    output logic [DM_AW-1:0] dm_r_add,
    output logic [DM_AW-1:0] dm_w_add,
    output logic             dm_rw,
    output logic [DW-1:0]    dm_ip,
    input  logic [DW-1:0]    dm_op,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [DW-1:0]   ir_q, ir_d;
    logic [DW-1:0]   a_q, a_d;
    logic            last_q, last_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        last_d  = last_q;
        if (!power) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
                ST_FETCH:  state_d = ST_DECODE;
                ST_DECODE: begin
                    ir_d   = imem_op;
                    last_d = (pc_q == last_add);
                    pc_d   = pc_q + PC_W'(1);
                    unique case (ir_op(imem_op))
                        OP_LOAD:          state_d = ST_MEM;
                        OP_STORE, OP_ADD: state_d = ST_RD_A;
                        OP_JMP: begin
                            // JMP retires here, so the halt decision cannot wait for last_q
                            pc_d    = PC_W'(ir_addr(imem_op));
                            state_d = (pc_q == last_add) ? ST_HALT : ST_FETCH;
                        end
                        default:          state_d = ST_IDLE;
                    endcase
                end
                ST_MEM:  state_d = ST_WB;
                ST_RD_A: state_d = (ir_op(ir_q) == OP_STORE) ? ST_ST : ST_RD_B;
                ST_RD_B: begin
                    a_d     = rb_op;
                    state_d = ST_WB;
                end
                ST_ST, ST_WB: state_d = last_q ? ST_HALT : ST_FETCH;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_add = '0;
        rb_r_add = '0;
        rb_w_add = '0;
        rb_rw    = 1'b1;
        rb_ip    = '0;
        dm_r_add = '0;
        dm_w_add = '0;
        dm_rw    = 1'b1;
        dm_ip    = '0;
        unique case (state_q)
            ST_FETCH: imem_add = pc_q;
            ST_MEM:   dm_r_add = ir_addr(ir_q);
            ST_RD_A:  rb_r_add = ir_rd(ir_q);
            ST_RD_B:  rb_r_add = ir_rs(ir_q);
            ST_ST: begin
                dm_w_add = ir_addr(ir_q);
                dm_ip    = rb_op;
                dm_rw    = ~power;
            end
            ST_WB: begin
                rb_w_add = ir_rd(ir_q);
                rb_rw    = ~power;
                rb_ip    = (ir_op(ir_q) == OP_LOAD) ? dm_op : a_q + rb_op;
            end
            default: ;
        endcase
    end

    assign imem_rw = 1'b1;
    assign pc      = pc_q;
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random programs
// compared against an instruction-level reference model.
module tb_cpu_sequencer;

    logic       clk;
    logic       reset;
    logic       power;
    logic [7:0] last_add;
    logic [7:0] imem_add;
    logic       imem_rw;
    logic [7:0] imem_op;
    logic [1:0] rb_r_add, rb_w_add;
    logic       rb_rw;
    logic [7:0] rb_ip, rb_op;
    logic [3:0] dm_r_add, dm_w_add;
    logic       dm_rw;
    logic [7:0] dm_ip, dm_op;
    logic [7:0] pc;
    logic       busy, halted;

    logic [7:0] imem [0:255];
    logic [7:0] rf   [0:3];
    logic [7:0] dm   [0:15];

    int n_assert = 0;
    int n_fail   = 0;

    cpu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .power    (power),
        .last_add (last_add),
        .imem_add (imem_add),
        .imem_rw  (imem_rw),
        .imem_op  (imem_op),
        .rb_r_add (rb_r_add),
        .rb_w_add (rb_w_add),
        .rb_rw    (rb_rw),
        .rb_ip    (rb_ip),
        .rb_op    (rb_op),
        .dm_r_add (dm_r_add),
        .dm_w_add (dm_w_add),
        .dm_rw    (dm_rw),
        .dm_ip    (dm_ip),
        .dm_op    (dm_op),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memories: registered read, write on the edge while rw=0
    always @(posedge clk) begin
        imem_op <= imem[imem_add];
        rb_op   <= rf[rb_r_add];
        dm_op   <= dm[dm_r_add];
        if (!rb_rw) rf[rb_w_add] = rb_ip;
        if (!dm_rw) dm[dm_w_add] = dm_ip;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        power = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick(1);
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        for (int i = 0; i < 4; i++)   rf[i]   = 8'h00;
        for (int i = 0; i < 16; i++)  dm[i]   = 8'h00;
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 1000) begin
            tick(1);
            cyc++;
        end
        if (!halted) chk("halt_timeout", int'(halted), 1);
    endtask

    logic [7:0] m_imem [0:15];
    logic [7:0] m_rf   [0:3];
    logic [7:0] m_dm   [0:15];
    logic [7:0] e_rf   [0:3];
    logic [7:0] e_dm   [0:15];

    initial begin : main
        int cyc, nwr, wcyc, L, mpc, tot, op;
        logic [7:0] ins;
        logic       fin;
        int pc_trace [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

        reset    = 1'b1;
        power    = 1'b0;
        last_add = 8'h00;
        clr_mem();
        #2;
        chk("rst_busy",     int'(busy),     0);
        chk("rst_halted",   int'(halted),   0);
        chk("rst_pc",       int'(pc),       0);
        chk("rst_imem_add", int'(imem_add), 0);
        chk("rst_imem_rw",  int'(imem_rw),  1);
        chk("rst_rb_rw",    int'(rb_rw),    1);
        chk("rst_dm_rw",    int'(dm_rw),    1);
        chk("rst_rb_ip",    int'(rb_ip),    0);
        chk("rst_dm_ip",    int'(dm_ip),    0);
        reset = 1'b0;
        tick(1);

        // LOAD r0 <- dm[1], single instruction
        clr_mem();
        imem[0] = 8'h01;
        dm[1]   = 8'h3C;
        last_add = 8'h00;
        power = 1'b1;
        tick(4);
        chk("t1_wb_rw",   int'(rb_rw),    0);
        chk("t1_wb_add",  int'(rb_w_add), 0);
        chk("t1_wb_data", int'(rb_ip),    8'h3C);
        tick(1);
        chk("t1_halted",  int'(halted),   1);
        chk("t1_r0",      int'(rf[0]),    8'h3C);
        chk("t1_pc",      int'(pc),       1);

        // Restart from HALT goes back to pc 0
        power = 1'b0;
        tick(1);
        chk("t6_idle_busy",   int'(busy),   0);
        chk("t6_idle_halted", int'(halted), 0);
        power = 1'b1;
        tick(1);
        chk("t6_fetch_add",  int'(imem_add), 0);
        chk("t6_fetch_busy", int'(busy),     1);
        power = 1'b0;
        tick(1);

        // ADD r1 += r2 with 8-bit wrap
        do_reset();
        clr_mem();
        rf[1] = 8'hF0;
        rf[2] = 8'h20;
        imem[0] = 8'b10_01_0010;
        last_add = 8'h00;
        power = 1'b1;
        wait_halt(cyc);
        chk("t2_cycles", cyc, 6);
        chk("t2_r1",     int'(rf[1]), 8'h10);
        chk("t2_r2",     int'(rf[2]), 8'h20);
        power = 1'b0;
        tick(1);

        // STORE r0 -> dm[5]; exactly one write cycle
        do_reset();
        clr_mem();
        rf[0] = 8'hA5;
        imem[0] = 8'b01_00_0101;
        last_add = 8'h00;
        power = 1'b1;
        nwr = 0;
        wcyc = 0;
        for (int c = 1; c <= 5; c++) begin
            tick(1);
            if (!dm_rw) begin
                nwr++;
                wcyc = c;
            end
        end
        chk("t3_nwrites", nwr, 1);
        chk("t3_wcycle",  wcyc, 4);
        chk("t3_dm5",     int'(dm[5]), 8'hA5);
        chk("t3_halted",  int'(halted), 1);
        power = 1'b0;
        tick(1);

        // Loop STORE/JMP 0 with last_add beyond reach; drop power mid-ST
        do_reset();
        clr_mem();
        rf[0] = 8'h5A;
        imem[0] = 8'b01_00_0111;
        imem[1] = 8'hC0;
        last_add = 8'h03;
        power = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            chk($sformatf("t4_pc_c%0d", c), int'(pc), pc_trace[c-1]);
            if (c == 5) begin
                chk("t4_first_store", int'(dm[7]), 8'h5A);
                dm[7] = 8'h00;
            end
        end
        chk("t4_st_rw_on", int'(dm_rw), 0);
        power = 1'b0;
        #1;
        chk("t4_st_rw_gated", int'(dm_rw), 1);
        tick(1);
        chk("t4_idle_busy", int'(busy), 0);
        chk("t4_no_write",  int'(dm[7]), 0);

        // Async reset during RD_B of an ADD
        do_reset();
        clr_mem();
        rf[3] = 8'h11;
        rf[2] = 8'h22;
        imem[0] = 8'b10_11_0010;
        last_add = 8'h00;
        power = 1'b1;
        tick(4);
        chk("t5_rdb_add",  int'(rb_r_add), 2);
        chk("t5_rdb_busy", int'(busy),     1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_busy",  int'(busy),     0);
        chk("t5_rst_radd",  int'(rb_r_add), 0);
        chk("t5_rst_pc",    int'(pc),       0);
        chk("t5_rst_rb_rw", int'(rb_rw),    1);
        power = 1'b0;
        reset = 1'b0;
        tick(2);
        chk("t5_no_wb", int'(rf[3]), 8'h11);

        // Random programs against an instruction-level model
        for (int t = 0; t < 16; t++) begin
            do_reset();
            clr_mem();
            L = $urandom_range(1, 12);
            for (int i = 0; i < 16; i++) m_imem[i] = 8'h00;
            for (int i = 0; i < 4; i++)  m_rf[i]   = 8'($urandom);
            for (int i = 0; i < 16; i++) m_dm[i]   = 8'($urandom);
            for (int i = 0; i <= L; i++) begin
                op = $urandom_range(0, 3);
                ins = {2'(op), 6'($urandom)};
                if (op == 3 && i < L) ins[3:0] = 4'($urandom_range(i + 1, L));
                m_imem[i] = ins;
            end
            for (int i = 0; i < 16; i++) imem[i] = m_imem[i];
            for (int i = 0; i < 4; i++)  rf[i]   = m_rf[i];
            for (int i = 0; i < 16; i++) dm[i]   = m_dm[i];
            last_add = 8'(L);

            e_rf = m_rf;
            e_dm = m_dm;
            mpc = 0;
            tot = 0;
            for (int s = 0; s < 64; s++) begin
                ins = m_imem[mpc];
                fin = (mpc == L);
                case (ins[7:6])
                    2'b00: begin e_rf[ins[5:4]] = e_dm[ins[3:0]]; tot += 4; mpc++; end
                    2'b01: begin e_dm[ins[3:0]] = e_rf[ins[5:4]]; tot += 4; mpc++; end
                    2'b10: begin e_rf[ins[5:4]] = e_rf[ins[5:4]] + e_rf[ins[1:0]]; tot += 5; mpc++; end
                    default: begin tot += 2; mpc = int'(ins[3:0]); end
                endcase
                if (fin) break;
            end

            power = 1'b1;
            wait_halt(cyc);
            chk($sformatf("rnd%0d_cycles", t), cyc, tot + 1);
            chk($sformatf("rnd%0d_pc", t), int'(pc), mpc & 255);
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd%0d_r%0d", t, i), int'(rf[i]), int'(e_rf[i]));
            for (int i = 0; i < 16; i++)
                chk($sformatf("rnd%0d_dm%0d", t, i), int'(dm[i]), int'(e_dm[i]));
            power = 1'b0;
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "time limit");
    end

endmodule
